// File: rtl/mdu_pkg.sv
// mdu_pkg: shared funct3 codes, FSM encoding and width default for the RV32M sequencer.
// Optional build macro MDU_EARLY_OUT_EN is consumed by mdu_seq.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: op-issue and result handshakes between the execute stage and mdu_seq.
// master = execute stage, slave = sequencer.
interface mdu_if #(
    parameter int XLEN = mdu_pkg::MDU_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, funct3, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, funct3, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mdu_signfix.sv
// mdu_signfix: two-lane conditional negate, used for operand magnitudes
// on the way in and for product/quotient/remainder sign fix on the way out.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         a_neg_i,
    input  logic [W-1:0] b_i,
    input  logic         b_neg_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);
    assign a_o = a_neg_i ? -a_i : a_i;
    assign b_o = b_neg_i ? -b_i : b_i;
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M mul/div sequencer, XLEN iterations of shift-add / restoring divide.
// Define MDU_EARLY_OUT_EN to bypass zero-operand muls and small-dividend divides.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input logic   clk,
    input logic   rst_n,
    input logic   flush,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q;
    logic              nega_q, negb_q;
    logic [XLEN-1:0]   result_q;

    logic [2:0]        f3;
    logic              sgn1, sgn2, neg1, neg2;
    logic              is_div, div0, ovf, byp;
    logic [XLEN-1:0]   mag1, mag2, byp_res, res_fix;
    logic [XLEN:0]     add_s, sub_s;
    logic [2*XLEN-1:0] fa, fb, fix_a, fix_b;
    logic              unused_hi;

    assign f3 = bus.funct3;

    always_comb begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
        unique case (f3)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            MDU_MULHSU: sgn1 = 1'b1;
            default: ;
        endcase
    end

    assign neg1 = sgn1 & bus.src1[XLEN-1];
    assign neg2 = sgn2 & bus.src2[XLEN-1];

    mdu_signfix #(.W(XLEN)) u_in_fix (
        .a_i     (bus.src1),
        .a_neg_i (neg1),
        .b_i     (bus.src2),
        .b_neg_i (neg2),
        .a_o     (mag1),
        .b_o     (mag2)
    );

    assign is_div = f3[2];
    assign div0   = is_div && (bus.src2 == '0);
    assign ovf    = (f3 == MDU_DIV || f3 == MDU_REM) &&
                    (bus.src1 == MIN_NEG) && (bus.src2 == '1);

    // f3[1] separates rem/remu from div/divu within the divide group
    always_comb begin
        byp     = 1'b0;
        byp_res = '0;
        if (div0) begin
            byp     = 1'b1;
            byp_res = f3[1] ? bus.src1 : '1;
        end else if (ovf) begin
            byp     = 1'b1;
            byp_res = f3[1] ? '0 : MIN_NEG;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div && (mag1 == '0 || mag2 == '0)) begin
            byp     = 1'b1;
            byp_res = '0;
        end else if (is_div && (mag1 < mag2)) begin
            byp     = 1'b1;
            byp_res = f3[1] ? bus.src1 : '0;
        end
`endif
    end

    assign add_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    assign sub_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};

    always_comb begin
        acc_d = acc_q;
        if (!f3_q[2]) begin
            acc_d = acc_q[0] ? {add_s, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN-1:1]};
        end else if (!sub_s[XLEN]) begin
            acc_d = {sub_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    // Sign fix sees the final iteration's value so it lands on DONE entry
    assign fa = f3_q[2] ? {{XLEN{1'b0}}, acc_d[XLEN-1:0]} : acc_d;
    assign fb = {{XLEN{1'b0}}, acc_d[2*XLEN-1:XLEN]};

    mdu_signfix #(.W(2*XLEN)) u_out_fix (
        .a_i     (fa),
        .a_neg_i (nega_q),
        .b_i     (fb),
        .b_neg_i (negb_q),
        .a_o     (fix_a),
        .b_o     (fix_b)
    );

    assign unused_hi = ^fix_b[2*XLEN-1:XLEN];

    always_comb begin
        res_fix = fix_b[XLEN-1:0];
        unique case (f3_q)
            MDU_MUL, MDU_DIV, MDU_DIVU:
                res_fix = fix_a[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:
                res_fix = fix_a[2*XLEN-1:XLEN];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            nega_q   <= 1'b0;
            negb_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        f3_q   <= f3;
                        cnt_q  <= '0;
                        nega_q <= neg1 ^ neg2;
                        negb_q <= neg1;
                        if (byp) begin
                            state_q  <= S_DONE;
                            result_q <= byp_res;
                        end else begin
                            state_q <= S_CALC;
                            mcand_q <= is_div ? mag2 : mag1;
                            acc_q   <= is_div ? {{XLEN{1'b0}}, mag1}
                                              : {{XLEN{1'b0}}, mag2};
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q  <= S_DONE;
                        result_q <= res_fix;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;

endmodule
